pll_lock_ctrl: RTL
==================

PLL_LOCK_CTRL -- requirements
Module: pll_lock_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer flops on pll_locked (min 2).
REQ-002 SHALL have parameter DEBOUNCE, default 8: consecutive synced-high samples needed to accept lock.
REQ-003 SHALL have parameter PLL_RST_CYCLES, default 16: pll_rst pulse width in refclk cycles.
REQ-004 SHALL have parameter LOCK_WAIT, default 50000: max cycles in WAIT_LOCK before retry (1 ms at 50 MHz).
REQ-005 SHALL have parameter HOLDOFF, default 1024: cycles of stable lock before system reset release.
REQ-006 SHALL have port refclk, input, 1: sole clock, free-running 50 MHz reference; all logic in this domain.
REQ-007 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port pll_locked, input, 1: PLL lock indicator, asynchronous to refclk.
REQ-009 SHALL have port pll_rst, output, 1: active-high reset to the PLL rst input.
REQ-010 SHALL have port sys_rst_n, output, 1: active-low reset for logic clocked by the PLL output.
REQ-011 SHALL have port ready, output, 1: high only in state RUN.
REQ-012 SHALL have port timeout, output, 1: single-cycle pulse on LOCK_WAIT expiry.
REQ-013 SHALL have port relock_cnt, output, 8: count of lock losses in RUN.

Function
REQ-014 SHALL implement states RESET_PLL, WAIT_LOCK, HOLDOFF, RUN; all outputs registered.
REQ-015 lock_db SHALL rise exactly SYNC_STAGES+DEBOUNCE refclk edges after pll_locked rises and stays high; it SHALL fall on the first synced-low sample and clear the debounce count.
REQ-016 RESET_PLL: pll_rst=1, sys_rst_n=0 for PLL_RST_CYCLES cycles, then -> WAIT_LOCK.
REQ-017 WAIT_LOCK: pll_rst=0; lock_db=1 -> HOLDOFF; wait counter reaching LOCK_WAIT -> RESET_PLL and pulse timeout.
REQ-018 HOLDOFF: after HOLDOFF consecutive cycles with lock_db=1 -> RUN; lock_db=0 -> WAIT_LOCK with holdoff and wait counters cleared and no PLL reset.
REQ-019 RUN: sys_rst_n=1, ready=1; lock_db=0 -> RESET_PLL on the next edge, relock_cnt+1.
REQ-020 sys_rst_n SHALL rise exactly SYNC_STAGES+DEBOUNCE+HOLDOFF cycles after a clean pll_locked rise in WAIT_LOCK.
REQ-021 relock_cnt SHALL saturate at 255, never wrap.
REQ-022 Counter widths SHALL be $clog2 of their parameter plus one, with no overflow at the maximum parameter value.
REQ-023 If lock loss and wait-counter expiry coincide, lock loss SHALL take priority; at most one state transition per cycle.

Reset
REQ-024 rst_n low SHALL asynchronously force: state=RESET_PLL, pll_rst=1, sys_rst_n=0, ready=0, timeout=0, relock_cnt=0, all counters and synchronizer flops 0.
REQ-025 Reset deassertion SHALL start the PLL_RST_CYCLES count on the first refclk edge; rst_n assertion in any state SHALL abort that state immediately.

Configuration
REQ-026 With PLL_LOCK_CTRL_STATS_EN defined: relock_cnt and the timeout pulse are implemented per REQ-012/019/021.
REQ-027 Without PLL_LOCK_CTRL_STATS_EN: relock_cnt tied to 0, timeout tied to 0, and their logic is absent; state behaviour is unchanged.

Structure
REQ-028 Package pll_lock_pkg SHALL hold the state enum type and the default parameter constants.
REQ-029 Sub-module lock_sync_debounce SHALL implement the synchronizer and debouncer (REQ-015), outputting lock_db.

Verification (SYNC_STAGES=2, DEBOUNCE=3, PLL_RST_CYCLES=4, LOCK_WAIT=20, HOLDOFF=8)
REQ-030 Bring-up: release rst_n; pll_rst high 4 cycles; pll_locked rises and holds -> sys_rst_n and ready rise exactly 13 cycles later.
REQ-031 Never lock: pll_locked=0 -> timeout pulses after 20 WAIT_LOCK cycles, pll_rst re-asserts 4 cycles, sequence repeats.
REQ-032 Glitch: pll_locked high 2 cycles then low -> ready stays 0, no HOLDOFF entry; next clean rise -> ready 13 cycles later.
REQ-033 Loss in RUN: drop pll_locked -> within 3 cycles ready=0, sys_rst_n=0, pll_rst=1, relock_cnt=1; 300 losses -> relock_cnt=255.
REQ-034 Drop in HOLDOFF at cycle 5 -> WAIT_LOCK, pll_rst stays 0, relock_cnt unchanged; relock -> ready 13 cycles after rise.
REQ-035 rst_n low mid-HOLDOFF -> same-cycle pll_rst=1, sys_rst_n=0, relock_cnt=0; undefined macro -> relock_cnt=0 and timeout=0 in every scenario.

Source files
------------

// File: rtl/pll_lock_pkg.sv
// Shared types and default configuration for the PLL lock controller.
package pll_lock_pkg;

    typedef enum logic [1:0] {
        ST_RESET_PLL = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_HOLDOFF   = 2'd2,
        ST_RUN       = 2'd3
    } lock_state_e;

    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_DEBOUNCE       = 8;
    localparam int DEF_PLL_RST_CYCLES = 16;
    localparam int DEF_LOCK_WAIT      = 50000;
    localparam int DEF_HOLDOFF        = 1024;

    // Saturating 8-bit increment; holds at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pll_lock_ctrl_lock_sync_debounce.sv
// Synchronizes the asynchronous pll_locked flag into refclk and debounces it
// into lock_db, which drops on the very first synchronized-low sample.
module lock_sync_debounce
    import pll_lock_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEBOUNCE    = DEF_DEBOUNCE
) (
    input  logic refclk,
    input  logic rst_n,
    input  logic pll_locked,
    output logic lock_db
);

    localparam int DB_W = $clog2(DEBOUNCE) + 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [DB_W-1:0]        db_cnt_r;
    logic                   lock_r;
    logic                   synced_s;

    assign synced_s = sync_r[SYNC_STAGES-1];

    // Metastability synchronizer chain for pll_locked.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], pll_locked};
        end
    end

    // Count consecutive synced-high samples; any low sample restarts the count.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_r <= '0;
            lock_r   <= 1'b0;
        end else if (!synced_s) begin
            db_cnt_r <= '0;
            lock_r   <= 1'b0;
        end else if (lock_r) begin
            db_cnt_r <= db_cnt_r;
            lock_r   <= 1'b1;
        end else if (db_cnt_r >= DB_LAST) begin
            db_cnt_r <= db_cnt_r;
            lock_r   <= 1'b1;
        end else begin
            db_cnt_r <= db_cnt_r + DB_W'(1);
            lock_r   <= 1'b0;
        end
    end

    // Gating with the synced sample lets a loss propagate without waiting a cycle.
    assign lock_db = lock_r & synced_s;

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL bring-up sequencer: pulses pll_rst, waits for a debounced lock, holds off,
// then releases sys_rst_n. Optional statistics under PLL_LOCK_CTRL_STATS_EN.
module pll_lock_ctrl
    import pll_lock_pkg::*;
#(
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int DEBOUNCE       = DEF_DEBOUNCE,
    parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int LOCK_WAIT      = DEF_LOCK_WAIT,
    parameter int HOLDOFF        = DEF_HOLDOFF
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       timeout,
    output logic [7:0] relock_cnt
);

    localparam int RST_W  = $clog2(PLL_RST_CYCLES) + 1;
    localparam int WAIT_W = $clog2(LOCK_WAIT) + 1;
    localparam int HOLD_W = $clog2(HOLDOFF) + 1;

    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(PLL_RST_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LOCK_WAIT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF - 1);

    lock_state_e       state_r, state_s;
    logic [RST_W-1:0]  rst_cnt_r, rst_cnt_s;
    logic [WAIT_W-1:0] wait_cnt_r, wait_cnt_s;
    logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_s;
    logic              pll_rst_r, pll_rst_s;
    logic              sys_rst_n_r, sys_rst_n_s;
    logic              ready_r, ready_s;
    logic              lock_db;

    lock_sync_debounce #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEBOUNCE    (DEBOUNCE)
    ) u_lock_sync_debounce (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .lock_db    (lock_db)
    );

    // Next-state, counter and output decode; counters clear on every state change.
    always_comb begin
        state_s    = state_r;
        rst_cnt_s  = '0;
        wait_cnt_s = '0;
        hold_cnt_s = '0;
        case (state_r)
            ST_RESET_PLL: begin
                if (rst_cnt_r >= RST_LAST) begin
                    state_s = ST_WAIT_LOCK;
                end else begin
                    rst_cnt_s = rst_cnt_r + RST_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                // The cycle that sees lock counts as the first stable-lock cycle.
                if (lock_db) begin
                    if (HOLDOFF <= 1) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s    = ST_HOLDOFF;
                        hold_cnt_s = HOLD_W'(1);
                    end
                end else if (wait_cnt_r >= WAIT_LAST) begin
                    state_s = ST_RESET_PLL;
                end else begin
                    wait_cnt_s = wait_cnt_r + WAIT_W'(1);
                end
            end
            ST_HOLDOFF: begin
                if (!lock_db) begin
                    state_s = ST_WAIT_LOCK;
                end else if (hold_cnt_r >= HOLD_LAST) begin
                    state_s = ST_RUN;
                end else begin
                    hold_cnt_s = hold_cnt_r + HOLD_W'(1);
                end
            end
            ST_RUN: begin
                if (!lock_db) begin
                    state_s = ST_RESET_PLL;
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: begin
                state_s = ST_RESET_PLL;
            end
        endcase
        pll_rst_s   = (state_s == ST_RESET_PLL);
        sys_rst_n_s = (state_s == ST_RUN);
        ready_s     = (state_s == ST_RUN);
    end

    // State, counters and registered outputs.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_RESET_PLL;
            rst_cnt_r   <= '0;
            wait_cnt_r  <= '0;
            hold_cnt_r  <= '0;
            pll_rst_r   <= 1'b1;
            sys_rst_n_r <= 1'b0;
            ready_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            rst_cnt_r   <= rst_cnt_s;
            wait_cnt_r  <= wait_cnt_s;
            hold_cnt_r  <= hold_cnt_s;
            pll_rst_r   <= pll_rst_s;
            sys_rst_n_r <= sys_rst_n_s;
            ready_r     <= ready_s;
        end
    end

    assign pll_rst   = pll_rst_r;
    assign sys_rst_n = sys_rst_n_r;
    assign ready     = ready_r;

`ifdef PLL_LOCK_CTRL_STATS_EN
    logic       timeout_s;
    logic       loss_s;
    logic       timeout_r;
    logic [7:0] relock_cnt_r;

    // Detect lock-wait expiry and lock loss in RUN for the current cycle.
    always_comb begin
        timeout_s = 1'b0;
        loss_s    = 1'b0;
        if ((state_r == ST_WAIT_LOCK) && !lock_db && (wait_cnt_r >= WAIT_LAST)) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
        if ((state_r == ST_RUN) && !lock_db) begin
            loss_s = 1'b1;
        end else begin
            loss_s = 1'b0;
        end
    end

    // Timeout pulse and saturating relock counter.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_r    <= 1'b0;
            relock_cnt_r <= 8'd0;
        end else begin
            timeout_r <= timeout_s;
            if (loss_s) begin
                relock_cnt_r <= sat_inc8(relock_cnt_r);
            end else begin
                relock_cnt_r <= relock_cnt_r;
            end
        end
    end

    assign timeout    = timeout_r;
    assign relock_cnt = relock_cnt_r;
`else
    assign timeout    = 1'b0;
    assign relock_cnt = 8'd0;
`endif

endmodule
